apb_master_arbiter: RTL and testbench
=====================================

Name: apb_master_arbiter

Overview:
Shares one APB master port among NUM_REQ network-interface requesters using round-robin arbitration. It sequences the APB IDLE/SETUP/ACCESS/DONE protocol for each granted transfer. It returns read data and error status to the winning requester. It sits between the NI request/response FSMs and the APB peripheral bus.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
ADDR_W, 32, APB address width
DATA_W, 32, APB data width
TIMEOUT_CYC, 255, max ACCESS cycles waiting for pready_i; 0 disables timeout

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
req_valid_i  in  NUM_REQ  per-requester transfer request
req_ready_o  out  NUM_REQ  one-hot accept pulse
req_write_i  in  NUM_REQ  1=write, 0=read
req_addr_i  in  NUM_REQ*ADDR_W  packed addresses, requester k at [k*ADDR_W +: ADDR_W]
req_wdata_i  in  NUM_REQ*DATA_W  packed write data
resp_valid_o  out  NUM_REQ  one-hot completion pulse
resp_rdata_o  out  DATA_W  read data, shared by all requesters
resp_err_o  out  1  pslverr or timeout
psel_o  out  1  APB select
penable_o  out  1  APB enable
pwrite_o  out  1  APB direction
paddr_o  out  ADDR_W  APB address
pwdata_o  out  DATA_W  APB write data
prdata_i  in  DATA_W  APB read data
pready_i  in  1  APB ready
pslverr_i  in  1  APB slave error

Behaviour:
- FSM uses apb_master_states_e: IDLE_ST, SETUP_ST, ACCESS_ST, DONE_ST. Reset state is IDLE_ST.
- Reset values: all registered outputs 0; resp_valid_o=0; last_grant=NUM_REQ-1, so requester 0 has first priority.
- req_ready_o is combinational: equals the grant vector when state==IDLE_ST and rst==0, else 0.
- IDLE_ST:
  - If any req_valid_i is set, grant the first set bit searching from last_grant+1, wrapping modulo NUM_REQ.
  - Pulse req_ready_o[g] (handshake completes in this cycle).
  - Latch write/addr/wdata of requester g into pwrite_o/paddr_o/pwdata_o and store g.
  - Go to SETUP_ST.
- SETUP_ST: psel_o=1, penable_o=0; clear timeout counter; go to ACCESS_ST unconditionally.
- ACCESS_ST: psel_o=1, penable_o=1.
  - If pready_i=1: capture prdata_i (only when pwrite_o=0, else capture 0) and pslverr_i; go to DONE_ST.
  - Else increment the timeout counter. When TIMEOUT_CYC!=0 and the counter reaches TIMEOUT_CYC: rdata=0, err=1, go to DONE_ST.
  - If pready_i and timeout coincide, pready_i wins.
- DONE_ST:
  - psel_o=0, penable_o=0.
  - resp_valid_o[g]=1 for exactly one cycle, with resp_rdata_o/resp_err_o valid in that cycle. Responses are not backpressured.
  - last_grant<=g; go to IDLE_ST.
- resp_rdata_o and resp_err_o hold their values until the next DONE_ST.
- paddr_o, pwrite_o and pwdata_o are stable from SETUP_ST through ACCESS_ST and hold until the next grant.
- Latency: accept at cycle N, SETUP at N+1, ACCESS from N+2, DONE one cycle after pready, earliest next accept at N+4.
- Requester rules:
  - Requesters hold valid and payload stable until ready.
  - Requests arriving outside IDLE_ST wait.
  - A requester deasserting valid before ready is illegal and is not checked.
- Timeout counter width is $clog2(TIMEOUT_CYC+1).
- Reset mid-transfer: all state is cleared on the reset edge. psel_o/penable_o are 0 the cycle after. The aborted transfer gets no resp_valid_o. Priority restarts at requester 0.

Decomposition:
- fsm_pkg: reuse apb_master_states_e unchanged. No new typedefs required.
- Sub-module rr_arbiter (params NUM_REQ):
  - inputs: req vector, last_grant index.
  - outputs: one-hot grant, grant index, any_grant.
  - purely combinational rotate / priority-encode / un-rotate.
- apb_master_arbiter instantiates rr_arbiter and holds the FSM, latches and timeout counter.

Test Plan:
- Write, zero wait: req 2 write, addr 0x10, wdata 0xDEADBEEF, pready_i=1 -> req_ready_o=4'b0100 at N; psel=1/penable=0 at N+1; penable=1 with paddr=0x10, pwdata=0xDEADBEEF at N+2; resp_valid_o=4'b0100, resp_err_o=0 at N+3.
- All 4 requesters continuously valid, pready_i=1 -> grant order 0,1,2,3,0, one accept every 4 cycles.
- Read from req 1 with pready_i low 3 ACCESS cycles then high, prdata_i=0xA5A5A5A5 -> penable high 4 cycles; resp_rdata_o=0xA5A5A5A5, resp_valid_o=4'b0010.
- pslverr_i=1 with pready_i=1 on a read -> resp_err_o=1, resp_rdata_o=prdata_i.
- TIMEOUT_CYC=8, pready_i held 0 -> DONE after 8 ACCESS cycles; resp_err_o=1, resp_rdata_o=0. Repeat with pready_i=1 on the 8th cycle -> resp_err_o=0.
- Reset during ACCESS_ST for req 3 with req 0 and req 3 valid afterwards -> psel_o/penable_o=0 the cycle after reset; no resp_valid_o; first post-reset grant goes to req 0.

Source files
------------

// File: rtl/apb_master_arbiter_pkg.sv
// Shared types for the APB master arbiter.
// Holds the transfer FSM states and index-width helper.
package apb_master_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE_ST,
    SETUP_ST,
    ACCESS_ST,
    DONE_ST
  } apb_master_states_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_master_arbiter_rr.sv
// Round-robin grant selection, purely combinational.
// Rotates requests past last_grant, picks the lowest, rotates back.
module rr_arbiter
  import apb_master_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IW = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_idx,
  output logic               any_grant
);

  logic [NUM_REQ-1:0] rot;
  logic [IW-1:0]      pos;
  logic               found;

  // rotate so that the requester after last_grant sits at bit 0
  always_comb begin
    rot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rot[i] = req[IW'((int'(last_grant) + 1 + i) % NUM_REQ)];
    end
  end

  // priority-encode the lowest set bit of the rotated vector
  always_comb begin
    pos   = '0;
    found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        pos   = IW'(i);
        found = 1'b1;
      end
    end
  end

  assign any_grant = found;
  assign grant_idx =
    IW'((int'(last_grant) + 1 + int'(pos)) % NUM_REQ);
  assign grant = found ? (NUM_REQ'(1) << grant_idx) : '0;

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB master port among several requesters.
// Round-robin grant, then SETUP/ACCESS/DONE with optional timeout.
module apb_master_arbiter
  import apb_master_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [NUM_REQ-1:0]        req_write_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]        resp_valid_o,
  output logic [DATA_W-1:0]         resp_rdata_o,
  output logic                      resp_err_o,
  output logic                      psel_o,
  output logic                      penable_o,
  output logic                      pwrite_o,
  output logic [ADDR_W-1:0]         paddr_o,
  output logic [DATA_W-1:0]         pwdata_o,
  input  logic [DATA_W-1:0]         prdata_i,
  input  logic                      pready_i,
  input  logic                      pslverr_i
);

  localparam int IW = idx_w(NUM_REQ);
  localparam int CW =
    (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam bit TO_EN = (TIMEOUT_CYC != 0);
  localparam logic [CW-1:0] TO_LAST =
    CW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic [IW-1:0] LAST_RST = IW'(NUM_REQ - 1);

  apb_master_states_e state;

  logic [IW-1:0]      last_grant;
  logic [IW-1:0]      cur_idx;
  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0]      arb_idx;
  logic               any_grant;
  logic [CW-1:0]      cnt;
  logic               timed_out;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req        (req_valid_i),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (arb_idx),
    .any_grant  (any_grant)
  );

  // accept pulse mirrors the grant only while idle
  assign req_ready_o =
    (state == IDLE_ST && !rst) ? grant : '0;

  // counter hitting its last value means this cycle is the final wait
  assign timed_out = TO_EN && (cnt == TO_LAST);

  // transfer sequencer with registered APB and response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE_ST;
      psel_o       <= 1'b0;
      penable_o    <= 1'b0;
      pwrite_o     <= 1'b0;
      paddr_o      <= '0;
      pwdata_o     <= '0;
      resp_valid_o <= '0;
      resp_rdata_o <= '0;
      resp_err_o   <= 1'b0;
      last_grant   <= LAST_RST;
      cur_idx      <= '0;
      cnt          <= '0;
    end else begin
      unique case (state)
        IDLE_ST: begin
          if (any_grant) begin
            pwrite_o  <= req_write_i[arb_idx];
            paddr_o   <= req_addr_i[arb_idx*ADDR_W +: ADDR_W];
            pwdata_o  <= req_wdata_i[arb_idx*DATA_W +: DATA_W];
            cur_idx   <= arb_idx;
            psel_o    <= 1'b1;
            penable_o <= 1'b0;
            state     <= SETUP_ST;
          end
        end
        SETUP_ST: begin
          penable_o <= 1'b1;
          cnt       <= '0;
          state     <= ACCESS_ST;
        end
        ACCESS_ST: begin
          if (pready_i) begin
            resp_rdata_o <= pwrite_o ? '0 : prdata_i;
            resp_err_o   <= pslverr_i;
            resp_valid_o <= NUM_REQ'(1) << cur_idx;
            psel_o       <= 1'b0;
            penable_o    <= 1'b0;
            state        <= DONE_ST;
          end else if (timed_out) begin
            resp_rdata_o <= '0;
            resp_err_o   <= 1'b1;
            resp_valid_o <= NUM_REQ'(1) << cur_idx;
            psel_o       <= 1'b0;
            penable_o    <= 1'b0;
            state        <= DONE_ST;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE_ST: begin
          resp_valid_o <= '0;
          last_grant   <= cur_idx;
          state        <= IDLE_ST;
        end
        default: begin
          state <= IDLE_ST;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Scoreboard bench for apb_master_arbiter.
// Slave timing/error is a pure function of the address.
module tb_apb_master_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid, req_ready, req_write, resp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   resp_rdata, pwdata, prdata;
  logic            resp_err, psel, penable, pwrite, pready, pslverr;
  logic [AW-1:0]   paddr;
  logic [AW-1:0]   a_q [N];
  logic [DW-1:0]   d_q [N];

  always_comb begin
    req_addr  = '0;
    req_wdata = '0;
    for (int k = 0; k < N; k++) begin
      req_addr[k*AW +: AW]  = a_q[k];
      req_wdata[k*DW +: DW] = d_q[k];
    end
  end

  apb_master_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_write_i(req_write), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .resp_valid_o(resp_valid),
    .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
    .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite),
    .paddr_o(paddr), .pwdata_o(pwdata), .prdata_i(prdata),
    .pready_i(pready), .pslverr_i(pslverr)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          g;
    logic [DW-1:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t sbq[$];
  logic [DW-1:0] mem_m [16];
  logic [DW-1:0] mem_s [16];
  int last_m = N - 1;
  int last_due = -1;
  int mode = 0;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_wdata;
  logic acc_write;
  int acc_cyc = -10;
  int acc_g = -1;

  function automatic int slv_wait(input logic [AW-1:0] a);
    return a[4] ? 0 : int'(a[3:0]);
  endfunction

  function automatic logic slv_err(input logic [AW-1:0] a);
    return a[6:5] == 2'b11;
  endfunction

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // model of one granted transfer, from the slave's address rules
  task automatic accept(input int g);
    exp_t x;
    int w;
    logic e;
    logic [3:0] key;
    w   = slv_wait(a_q[g]);
    e   = slv_err(a_q[g]);
    key = a_q[g][11:8];
    x.g = g;
    if (w >= TO) begin
      x.rdata = '0;
      x.err   = 1'b1;
      x.due   = cyc + 3 + TO - 1;
    end else begin
      x.due = cyc + 3 + w;
      x.err = e;
      if (req_write[g]) begin
        x.rdata = '0;
        if (!e) mem_m[key] = d_q[g];
      end else begin
        x.rdata = mem_m[key];
      end
    end
    sbq.push_back(x);
    last_due  = x.due;
    last_m    = g;
    acc_addr  = a_q[g];
    acc_wdata = d_q[g];
    acc_write = req_write[g];
    acc_cyc   = cyc;
    acc_g     = g;
  endtask

  task automatic new_txn(input int k);
    logic [AW-1:0] a;
    a = {20'h0, 4'($urandom_range(0, 15)),
         8'($urandom_range(0, 255))};
    if (mode == 2) a[4] = 1'b1;
    a_q[k]       = a;
    d_q[k]       = $urandom;
    req_write[k] = 1'($urandom_range(0, 1));
    req_valid[k] = 1'b1;
  endtask

  // one clock: check accept at negedge, update requesters after posedge
  task automatic step();
    logic [N-1:0] rdy, exp_rdy, took;
    int pick;
    @(negedge clk);
    rdy = req_ready;
    exp_rdy = '0;
    pick = -1;
    if (!rst && cyc > last_due) begin
      for (int i = 1; i <= N; i++) begin
        int k;
        k = (last_m + i) % N;
        if (pick < 0 && req_valid[k]) pick = k;
      end
    end
    if (pick >= 0) exp_rdy[pick] = 1'b1;
    check("req_ready", 64'(rdy), 64'(exp_rdy));
    took = '0;
    if (pick >= 0 && rdy == exp_rdy) begin
      accept(pick);
      took[pick] = 1'b1;
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      if (took[k]) req_valid[k] = 1'b0;
    end
    for (int k = 0; k < N; k++) begin
      if (!req_valid[k] && mode != 0 &&
          (mode == 2 || $urandom_range(0, 2) == 0))
        new_txn(k);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      if (sbq.size() == 0 && req_valid == '0) break;
      step();
    end
    check("drain", 64'(sbq.size() == 0 && req_valid == '0), 64'(1));
  endtask

  task automatic issue(input int k, input logic w,
                       input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    a_q[k] = a;
    d_q[k] = d;
    req_write[k] = w;
    req_valid[k] = 1'b1;
    drain();
  endtask

  // APB slave: waits/errors from the address, backing store in mem_s
  initial begin
    int acc;
    logic in_acc;
    in_acc = 1'b0;
    acc = 0;
    pready = 1'b0;
    pslverr = 1'b0;
    prdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (psel && !penable) begin
        check("setup_cycle", 64'(cyc), 64'(acc_cyc + 1));
        check("setup_addr", 64'(paddr), 64'(acc_addr));
        check("setup_write", 64'(pwrite), 64'(acc_write));
        if (acc_write) check("setup_wdata", 64'(pwdata), 64'(acc_wdata));
      end
      if (psel && penable) begin
        if (!in_acc) begin
          in_acc = 1'b1;
          acc = 0;
        end else begin
          acc++;
        end
        pready  = (acc == slv_wait(paddr));
        pslverr = pready & slv_err(paddr);
        prdata  = pwrite ? $urandom : mem_s[paddr[11:8]];
        if (pready && pwrite && !pslverr) mem_s[paddr[11:8]] = pwdata;
      end else begin
        in_acc  = 1'b0;
        pready  = 1'($urandom_range(0, 1));
        pslverr = 1'($urandom_range(0, 1));
        prdata  = $urandom;
      end
    end
  end

  // response monitor: pops the scoreboard on every completion pulse
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0 && sbq[0].due < cyc) begin
        tests++;
        fails++;
        $display("FAIL resp_missing: req %0d due %0d now %0d",
                 sbq[0].g, sbq[0].due, cyc);
        void'(sbq.pop_front());
      end
      if (resp_valid != '0) begin
        if (sbq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL resp_unexpected: got %b expected none",
                   resp_valid);
        end else begin
          x = sbq.pop_front();
          check("resp_valid", 64'(resp_valid), 64'(1) << x.g);
          check("resp_cycle", 64'(cyc), 64'(x.due));
          check("resp_rdata", 64'(resp_rdata), 64'(x.rdata));
          check("resp_err", 64'(resp_err), 64'(x.err));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem_m[i] = 32'h5A00_0000 + 32'(i * 32'h0101);
      mem_s[i] = 32'h5A00_0000 + 32'(i * 32'h0101);
    end
    for (int k = 0; k < N; k++) begin
      a_q[k] = '0;
      d_q[k] = '0;
    end
    req_valid = '0;
    req_write = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_psel", 64'(psel), 64'(0));
    check("rst_penable", 64'(penable), 64'(0));
    check("rst_resp_valid", 64'(resp_valid), 64'(0));
    check("rst_req_ready", 64'(req_ready), 64'(0));
    check("rst_paddr", 64'(paddr), 64'(0));
    check("rst_rdata", 64'(resp_rdata), 64'(0));
    check("rst_err", 64'(resp_err), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    issue(2, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    issue(0, 1'b1, 32'h0000_0110, 32'hA5A5_A5A5);
    issue(1, 1'b0, 32'h0000_0103, 32'h0);
    issue(3, 1'b0, 32'h0000_0070, 32'h0);
    issue(0, 1'b0, 32'h0000_020F, 32'h0);
    issue(2, 1'b0, 32'h0000_0207, 32'h0);

    mode = 1;
    repeat (1500) step();
    mode = 0;
    drain();
    mode = 2;
    repeat (200) step();
    mode = 0;
    drain();

    a_q[3] = 32'h0000_030F;
    req_write[3] = 1'b0;
    req_valid[3] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (sbq.size() > 0 && cyc >= acc_cyc + 3) break;
    end
    check("pre_rst_access", 64'(psel & penable), 64'(1));
    rst = 1'b1;
    a_q[0] = 32'h0000_0410;
    d_q[0] = 32'h1111_2222;
    req_write[0] = 1'b1;
    req_valid[0] = 1'b1;
    a_q[3] = 32'h0000_0510;
    d_q[3] = 32'h3333_4444;
    req_write[3] = 1'b1;
    req_valid[3] = 1'b1;
    step();
    rst = 1'b0;
    sbq.delete();
    last_m = N - 1;
    last_due = -1;
    check("post_rst_psel", 64'(psel), 64'(0));
    check("post_rst_penable", 64'(penable), 64'(0));
    check("post_rst_resp", 64'(resp_valid), 64'(0));
    step();
    check("post_rst_grant", 64'(acc_g), 64'(0));
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
